// File: rtl/plic_irq_axil_forwarder.sv
// plic_irq_axil_forwarder
// Mirrors each PLIC target's interrupt level into a memory-mapped register
// through AXI4-Lite writes. Only level changes are written. A write that
// completes with a non-OKAY response leaves the target dirty, so it is retried.
// Targets are served round-robin, with one write outstanding at a time.
// The read channels are tied off.

module plic_irq_axil_forwarder #(
    parameter int          num_targets_p     = 2,
    parameter int          axil_data_width_p = 32,
    parameter int          axil_addr_width_p = 32,
    parameter int unsigned irq_base_addr_p   = 32'h0030_a000,
    parameter int unsigned target_stride_p   = 32'd4,
    parameter int          err_cnt_width_p   = 8
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [num_targets_p-1:0]       irq_i,

    output logic [axil_addr_width_p-1:0]   m_axil_awaddr_o,
    output logic [2:0]                     m_axil_awprot_o,
    output logic                           m_axil_awvalid_o,
    input  logic                           m_axil_awready_i,
    output logic [axil_data_width_p-1:0]   m_axil_wdata_o,
    output logic [axil_data_width_p/8-1:0] m_axil_wstrb_o,
    output logic                           m_axil_wvalid_o,
    input  logic                           m_axil_wready_i,
    input  logic [1:0]                     m_axil_bresp_i,
    input  logic                           m_axil_bvalid_i,
    output logic                           m_axil_bready_o,

    output logic [axil_addr_width_p-1:0]   m_axil_araddr_o,
    output logic [2:0]                     m_axil_arprot_o,
    output logic                           m_axil_arvalid_o,
    input  logic                           m_axil_arready_i,
    input  logic [axil_data_width_p-1:0]   m_axil_rdata_i,
    input  logic [1:0]                     m_axil_rresp_i,
    input  logic                           m_axil_rvalid_i,
    output logic                           m_axil_rready_o,

    output logic [err_cnt_width_p-1:0]     err_cnt_o,
    output logic                           busy_o
);

    localparam int idx_w_lp = (num_targets_p > 1) ? $clog2(num_targets_p) : 1;

    localparam logic [1:0] st_idle_c = 2'd0;
    localparam logic [1:0] st_send_c = 2'd1;
    localparam logic [1:0] st_resp_c = 2'd2;

    localparam logic [idx_w_lp-1:0]        last_idx_c = idx_w_lp'(num_targets_p - 1);
    localparam logic [err_cnt_width_p-1:0] err_max_c  = {err_cnt_width_p{1'b1}};

    logic [1:0]                   state_r;
    logic [num_targets_p-1:0]     irq_r;
    logic [num_targets_p-1:0]     sent_r;
    logic [idx_w_lp-1:0]          rr_ptr_r;
    logic [idx_w_lp-1:0]          sel_r;
    logic                         lvl_r;
    logic                         aw_done_r;
    logic                         w_done_r;
    logic [axil_addr_width_p-1:0] awaddr_r;
    logic [axil_data_width_p-1:0] wdata_r;
    logic                         awvalid_r;
    logic                         wvalid_r;
    logic                         bready_r;
    logic [err_cnt_width_p-1:0]   err_cnt_r;

    logic [num_targets_p-1:0]     dirty_s;
    logic                         found_s;
    logic [idx_w_lp-1:0]          sel_s;
    logic                         lvl_s;
    logic [axil_addr_width_p-1:0] addr_s;
    logic                         aw_fin_s;
    logic                         w_fin_s;
    logic                         unused_s;

    assign dirty_s = irq_r ^ sent_r;

    // Pick the first dirty target at or after rr_ptr_r, wrapping round.
    always_comb begin
        int            idx_v;
        logic [idx_w_lp-1:0] idx_t;
        found_s = 1'b0;
        sel_s   = '0;
        idx_v   = 0;
        idx_t   = '0;
        for (int k = 0; k < num_targets_p; k++) begin
            idx_v = int'(rr_ptr_r) + k;
            if (idx_v >= num_targets_p) begin
                idx_v = idx_v - num_targets_p;
            end else begin
                idx_v = idx_v;
            end
            idx_t = idx_w_lp'(idx_v);
            if (!found_s && dirty_s[idx_t]) begin
                found_s = 1'b1;
                sel_s   = idx_t;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Level and register address for the candidate target.
    always_comb begin
        lvl_s  = irq_r[sel_s];
        addr_s = axil_addr_width_p'(irq_base_addr_p)
               + axil_addr_width_p'(sel_s) * axil_addr_width_p'(target_stride_p);
    end

    // A channel is complete once it was done earlier or handshakes in this cycle.
    always_comb begin
        aw_fin_s = aw_done_r | (awvalid_r & m_axil_awready_i);
        w_fin_s  = w_done_r  | (wvalid_r  & m_axil_wready_i);
    end

    // Input sampling, write sequencing, round-robin pointer and error counter.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r   <= st_idle_c;
            irq_r     <= '0;
            sent_r    <= '0;
            rr_ptr_r  <= '0;
            sel_r     <= '0;
            lvl_r     <= 1'b0;
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
            awaddr_r  <= '0;
            wdata_r   <= '0;
            awvalid_r <= 1'b0;
            wvalid_r  <= 1'b0;
            bready_r  <= 1'b0;
            err_cnt_r <= '0;
        end else begin
            irq_r <= irq_i;
            case (state_r)
                st_idle_c: begin
                    if (found_s) begin
                        sel_r     <= sel_s;
                        lvl_r     <= lvl_s;
                        awaddr_r  <= addr_s;
                        wdata_r   <= axil_data_width_p'(lvl_s);
                        awvalid_r <= 1'b1;
                        wvalid_r  <= 1'b1;
                        state_r   <= st_send_c;
                    end
                end
                st_send_c: begin
                    if (awvalid_r && m_axil_awready_i) begin
                        awvalid_r <= 1'b0;
                    end
                    if (wvalid_r && m_axil_wready_i) begin
                        wvalid_r <= 1'b0;
                    end
                    if (aw_fin_s && w_fin_s) begin
                        aw_done_r <= 1'b0;
                        w_done_r  <= 1'b0;
                        bready_r  <= 1'b1;
                        state_r   <= st_resp_c;
                    end else begin
                        aw_done_r <= aw_fin_s;
                        w_done_r  <= w_fin_s;
                    end
                end
                st_resp_c: begin
                    if (m_axil_bvalid_i) begin
                        if (m_axil_bresp_i == 2'b00) begin
                            sent_r[sel_r] <= lvl_r;
                        end else if (err_cnt_r != err_max_c) begin
                            err_cnt_r <= err_cnt_r + {{(err_cnt_width_p-1){1'b0}}, 1'b1};
                        end
                        if (sel_r == last_idx_c) begin
                            rr_ptr_r <= '0;
                        end else begin
                            rr_ptr_r <= sel_r + {{(idx_w_lp-1){1'b0}}, 1'b1};
                        end
                        bready_r <= 1'b0;
                        state_r  <= st_idle_c;
                    end
                end
                default: begin
                    awvalid_r <= 1'b0;
                    wvalid_r  <= 1'b0;
                    bready_r  <= 1'b0;
                    aw_done_r <= 1'b0;
                    w_done_r  <= 1'b0;
                    state_r   <= st_idle_c;
                end
            endcase
        end
    end

    assign m_axil_awaddr_o  = awaddr_r;
    assign m_axil_awprot_o  = 3'b000;
    assign m_axil_awvalid_o = awvalid_r;
    assign m_axil_wdata_o   = wdata_r;
    assign m_axil_wstrb_o   = {(axil_data_width_p/8){1'b1}};
    assign m_axil_wvalid_o  = wvalid_r;
    assign m_axil_bready_o  = bready_r;

    assign m_axil_araddr_o  = '0;
    assign m_axil_arprot_o  = 3'b000;
    assign m_axil_arvalid_o = 1'b0;
    assign m_axil_rready_o  = 1'b1;

    assign err_cnt_o = err_cnt_r;
    assign busy_o    = (state_r != st_idle_c);

    // The read channel is never used; any stray response is simply drained.
    assign unused_s = ^{m_axil_arready_i, m_axil_rdata_i, m_axil_rresp_i, m_axil_rvalid_i};

endmodule

// File: tb/tb_plic_irq_axil_forwarder.sv
// Directed bench for plic_irq_axil_forwarder. The bench itself acts as the
// AXI-Lite slave. Inputs are driven and outputs sampled on the falling edge.

module tb_plic_irq_axil_forwarder;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [1:0]  irq_i;
    logic [31:0] m_axil_awaddr_o;
    logic [2:0]  m_axil_awprot_o;
    logic        m_axil_awvalid_o;
    logic        m_axil_awready_i;
    logic [31:0] m_axil_wdata_o;
    logic [3:0]  m_axil_wstrb_o;
    logic        m_axil_wvalid_o;
    logic        m_axil_wready_i;
    logic [1:0]  m_axil_bresp_i;
    logic        m_axil_bvalid_i;
    logic        m_axil_bready_o;
    logic [31:0] m_axil_araddr_o;
    logic [2:0]  m_axil_arprot_o;
    logic        m_axil_arvalid_o;
    logic        m_axil_arready_i;
    logic [31:0] m_axil_rdata_i;
    logic [1:0]  m_axil_rresp_i;
    logic        m_axil_rvalid_i;
    logic        m_axil_rready_o;
    logic [7:0]  err_cnt_o;
    logic        busy_o;

    int total_r = 0;
    int bad_r   = 0;

    plic_irq_axil_forwarder dut (
        .clk_i(clk_i), .reset_i(reset_i), .irq_i(irq_i),
        .m_axil_awaddr_o(m_axil_awaddr_o), .m_axil_awprot_o(m_axil_awprot_o),
        .m_axil_awvalid_o(m_axil_awvalid_o), .m_axil_awready_i(m_axil_awready_i),
        .m_axil_wdata_o(m_axil_wdata_o), .m_axil_wstrb_o(m_axil_wstrb_o),
        .m_axil_wvalid_o(m_axil_wvalid_o), .m_axil_wready_i(m_axil_wready_i),
        .m_axil_bresp_i(m_axil_bresp_i), .m_axil_bvalid_i(m_axil_bvalid_i),
        .m_axil_bready_o(m_axil_bready_o),
        .m_axil_araddr_o(m_axil_araddr_o), .m_axil_arprot_o(m_axil_arprot_o),
        .m_axil_arvalid_o(m_axil_arvalid_o), .m_axil_arready_i(m_axil_arready_i),
        .m_axil_rdata_i(m_axil_rdata_i), .m_axil_rresp_i(m_axil_rresp_i),
        .m_axil_rvalid_i(m_axil_rvalid_i), .m_axil_rready_o(m_axil_rready_o),
        .err_cnt_o(err_cnt_o), .busy_o(busy_o)
    );

    // Free-running clock.
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_r++;
        if (got !== exp) begin
            bad_r++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Wait for a request, check it, and complete AW and W after the given delays.
    task automatic serve_req(input string tag, input logic [31:0] ea, input logic [31:0] ed,
                             input int aw_dly, input int w_dly);
        int n;
        bit aw_got;
        bit w_got;
        n = 0;
        while (m_axil_awvalid_o !== 1'b1 && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        chk({tag, "_awvalid"}, 32'(m_axil_awvalid_o), 32'd1);
        chk({tag, "_wvalid"}, 32'(m_axil_wvalid_o), 32'd1);
        chk({tag, "_awaddr"}, m_axil_awaddr_o, ea);
        chk({tag, "_wdata"}, m_axil_wdata_o, ed);
        chk({tag, "_wstrb"}, 32'(m_axil_wstrb_o), 32'hF);
        chk({tag, "_busy"}, 32'(busy_o), 32'd1);
        aw_got = 1'b0;
        w_got  = 1'b0;
        n = 0;
        while (!(aw_got && w_got) && n < 40) begin
            chk({tag, "_bready_early"}, 32'(m_axil_bready_o), 32'd0);
            m_axil_awready_i = (!aw_got && n >= aw_dly);
            m_axil_wready_i  = (!w_got && n >= w_dly);
            @(negedge clk_i);
            n++;
            if (m_axil_awready_i) begin
                aw_got = 1'b1;
                chk({tag, "_awdrop"}, 32'(m_axil_awvalid_o), 32'd0);
            end else if (!aw_got) begin
                chk({tag, "_awhold"}, 32'(m_axil_awvalid_o), 32'd1);
                chk({tag, "_awaddr_hold"}, m_axil_awaddr_o, ea);
            end
            if (m_axil_wready_i) begin
                w_got = 1'b1;
                chk({tag, "_wdrop"}, 32'(m_axil_wvalid_o), 32'd0);
            end else if (!w_got) begin
                chk({tag, "_whold"}, 32'(m_axil_wvalid_o), 32'd1);
                chk({tag, "_wdata_hold"}, m_axil_wdata_o, ed);
            end
            m_axil_awready_i = 1'b0;
            m_axil_wready_i  = 1'b0;
        end
        chk({tag, "_bready"}, 32'(m_axil_bready_o), 32'd1);
    endtask

    // Return a write response after b_dly idle cycles.
    task automatic serve_resp(input string tag, input logic [1:0] resp, input int b_dly);
        for (int i = 0; i < b_dly; i++) begin
            @(negedge clk_i);
            chk({tag, "_bready_wait"}, 32'(m_axil_bready_o), 32'd1);
        end
        m_axil_bvalid_i = 1'b1;
        m_axil_bresp_i  = resp;
        @(negedge clk_i);
        m_axil_bvalid_i = 1'b0;
        m_axil_bresp_i  = 2'b00;
        chk({tag, "_bready_drop"}, 32'(m_axil_bready_o), 32'd0);
        chk({tag, "_idle"}, 32'(busy_o), 32'd0);
        chk({tag, "_no_back2back"}, 32'(m_axil_awvalid_o), 32'd0);
    endtask

    initial begin
        reset_i = 1'b1;
        irq_i = 2'b00;
        m_axil_awready_i = 1'b0;
        m_axil_wready_i  = 1'b0;
        m_axil_bresp_i   = 2'b00;
        m_axil_bvalid_i  = 1'b0;
        m_axil_arready_i = 1'b0;
        m_axil_rdata_i   = 32'h0;
        m_axil_rresp_i   = 2'b00;
        m_axil_rvalid_i  = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("rst_awvalid", 32'(m_axil_awvalid_o), 32'd0);
        chk("rst_wvalid", 32'(m_axil_wvalid_o), 32'd0);
        chk("rst_bready", 32'(m_axil_bready_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_err", 32'(err_cnt_o), 32'd0);
        chk("rst_arvalid", 32'(m_axil_arvalid_o), 32'd0);
        chk("rst_rready", 32'(m_axil_rready_o), 32'd1);
        chk("rst_awprot", 32'(m_axil_awprot_o), 32'd0);
        reset_i = 1'b0;
        @(negedge clk_i);

        // Single write, with dispatch latency checked.
        irq_i = 2'b01;
        @(negedge clk_i);
        chk("lat1_awvalid", 32'(m_axil_awvalid_o), 32'd0);
        @(negedge clk_i);
        chk("lat2_awvalid", 32'(m_axil_awvalid_o), 32'd1);
        serve_req("t1", 32'h0030_a000, 32'd1, 0, 0);
        serve_resp("t1", 2'b00, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            chk("t1_quiet", 32'({m_axil_awvalid_o, busy_o}), 32'd0);
        end

        // Round-robin order, starting from the pointer left by the last write.
        irq_i = 2'b11;
        serve_req("rr1", 32'h0030_a004, 32'd1, 0, 0);
        serve_resp("rr1", 2'b00, 0);
        irq_i = 2'b00;
        serve_req("rr2", 32'h0030_a000, 32'd0, 0, 0);
        serve_resp("rr2", 2'b00, 0);
        serve_req("rr3", 32'h0030_a004, 32'd0, 0, 0);
        serve_resp("rr3", 2'b00, 0);

        // Error response followed by a retry of the same write.
        irq_i = 2'b01;
        serve_req("er1", 32'h0030_a000, 32'd1, 0, 0);
        serve_resp("er1", 2'b10, 0);
        chk("er1_cnt", 32'(err_cnt_o), 32'd1);
        serve_req("er2", 32'h0030_a000, 32'd1, 0, 0);
        serve_resp("er2", 2'b00, 0);
        chk("er2_cnt", 32'(err_cnt_o), 32'd1);

        // Error counter saturation.
        irq_i = 2'b11;
        for (int i = 0; i < 254; i++) begin
            serve_req("sat", 32'h0030_a004, 32'd1, 0, 0);
            serve_resp("sat", 2'b11, 0);
        end
        chk("sat_255", 32'(err_cnt_o), 32'd255);
        for (int i = 0; i < 2; i++) begin
            serve_req("sat2", 32'h0030_a004, 32'd1, 0, 0);
            serve_resp("sat2", 2'b10, 0);
        end
        chk("sat_hold", 32'(err_cnt_o), 32'd255);
        serve_req("sat_ok", 32'h0030_a004, 32'd1, 0, 0);
        serve_resp("sat_ok", 2'b00, 0);

        // Skewed handshakes: W three cycles ahead of AW, then the reverse.
        irq_i = 2'b10;
        serve_req("skw", 32'h0030_a000, 32'd0, 3, 0);
        serve_resp("skw", 2'b00, 0);
        irq_i = 2'b00;
        serve_req("ska", 32'h0030_a004, 32'd0, 0, 3);
        serve_resp("ska", 2'b00, 0);

        // A level change while the response is pending causes a follow-up write.
        irq_i = 2'b01;
        serve_req("tg0", 32'h0030_a000, 32'd1, 0, 0);
        serve_resp("tg0", 2'b00, 0);
        irq_i = 2'b00;
        serve_req("tg1", 32'h0030_a000, 32'd0, 0, 0);
        irq_i = 2'b01;
        serve_resp("tg1", 2'b00, 2);
        serve_req("tg2", 32'h0030_a000, 32'd1, 0, 0);
        serve_resp("tg2", 2'b00, 0);

        // Asynchronous reset while a write is in flight.
        irq_i = 2'b11;
        serve_req("pre", 32'h0030_a004, 32'd1, 5, 5);
        #2;
        reset_i = 1'b1;
        #1;
        chk("ar_awvalid", 32'(m_axil_awvalid_o), 32'd0);
        chk("ar_wvalid", 32'(m_axil_wvalid_o), 32'd0);
        chk("ar_bready", 32'(m_axil_bready_o), 32'd0);
        chk("ar_busy", 32'(busy_o), 32'd0);
        chk("ar_err", 32'(err_cnt_o), 32'd0);
        @(negedge clk_i);
        reset_i = 1'b0;
        serve_req("rs0", 32'h0030_a000, 32'd1, 0, 0);
        serve_resp("rs0", 2'b00, 0);
        serve_req("rs1", 32'h0030_a004, 32'd1, 0, 0);
        serve_resp("rs1", 2'b00, 0);
        repeat (3) @(negedge clk_i);
        chk("end_idle", 32'({m_axil_awvalid_o, busy_o}), 32'd0);

        $display("test done: total=%0d bad=%0d", total_r, bad_r);
        $finish;
    end

endmodule
